// File: rtl/video_src_switch_if.sv
// Bundle of per-source video inputs, the source request and the selected output stream.
// The slave side is the switch; the master side drives sources and observes the output.
interface video_src_switch_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
);
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC*3*DATA_W-1:0] src_rgb;
    logic [NUM_SRC-1:0]          src_hsync;
    logic [NUM_SRC-1:0]          src_vsync;
    logic [NUM_SRC-1:0]          src_de;
    logic [SEL_W-1:0]            sel_in;
    logic [3*DATA_W-1:0]         rgb_out;
    logic                        hsync_out;
    logic                        vsync_out;
    logic                        de_out;
    logic [SEL_W-1:0]            active_sel;
    logic                        switch_busy;

    modport slave (
        input  src_rgb, src_hsync, src_vsync, src_de, sel_in,
        output rgb_out, hsync_out, vsync_out, de_out, active_sel, switch_busy
    );

    modport master (
        output src_rgb, src_hsync, src_vsync, src_de, sel_in,
        input  rgb_out, hsync_out, vsync_out, de_out, active_sel, switch_busy
    );
endinterface

// File: rtl/video_src_switch.sv
// N-way video source selector: selection changes take effect on the current source's
// vsync leading edge (or after a timeout), optionally followed by black frames.
module video_src_switch #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_W       = 8,
    parameter bit SYNC_POL     = 1'b1,
    parameter int DEFAULT_SRC  = 0,
    parameter int BLACK_FRAMES = 1,
    parameter int TIMEOUT_CYC  = 2000000
) (
    input  logic               pix_clk,
    input  logic               rst,
    video_src_switch_if.slave  vid
);
    localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PIX_W  = 3 * DATA_W;
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int BCNT_W = (BLACK_FRAMES > 0) ? $clog2(BLACK_FRAMES + 1) : 1;

    localparam logic [SEL_W:0]    NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);
    localparam logic [SEL_W-1:0]  DEF_SEL   = SEL_W'(DEFAULT_SRC);
    localparam logic [TCNT_W-1:0] TLAST     = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [BCNT_W-1:0] BLOAD     = BCNT_W'(BLACK_FRAMES);
    localparam logic              IDLE_SYNC = ~SYNC_POL;

    typedef enum logic [1:0] {RUN, PENDING, BLANK} state_t;

    function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
        return (v == {TCNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t              state_q;
    logic [SEL_W-1:0]    active_sel_q;
    logic [SEL_W-1:0]    pend_sel_q;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [BCNT_W-1:0]   bcnt_q;
    logic                busy_q;
    logic [NUM_SRC-1:0]  vs_d_q;
    logic [PIX_W-1:0]    rgb_q;
    logic                hs_q;
    logic                vs_q;
    logic                de_q;

    logic [NUM_SRC-1:0]  lead;
    logic                lead_act;
    logic                sel_ok;
    logic                switch_now;
    logic                blank_end;
    logic                mute_d;
    logic [SEL_W-1:0]    mux_sel;
    logic [PIX_W-1:0]    sel_rgb;

    // Leading edge = transition into the active sync level, whatever the polarity.
    assign lead       = (SYNC_POL ? vid.src_vsync : ~vid.src_vsync) & (SYNC_POL ? ~vs_d_q : vs_d_q);
    assign lead_act   = lead[active_sel_q];
    assign sel_ok     = {1'b0, vid.sel_in} < NUM_SRC_L;
    assign switch_now = (state_q == PENDING) && (lead_act || (tcnt_q == TLAST));
    assign mux_sel    = switch_now ? pend_sel_q : active_sel_q;
    assign sel_rgb    = vid.src_rgb[int'(mux_sel)*PIX_W +: PIX_W];
    assign blank_end  = lead_act && (bcnt_q == BCNT_W'(1));
    // The switch cycle's sample is already the new source, so it is muted too.
    assign mute_d     = (switch_now && (BLACK_FRAMES != 0)) || ((state_q == BLANK) && !blank_end);

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            state_q      <= RUN;
            active_sel_q <= DEF_SEL;
            pend_sel_q   <= DEF_SEL;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            busy_q       <= 1'b0;
            vs_d_q       <= {NUM_SRC{IDLE_SYNC}};
            rgb_q        <= '0;
            hs_q         <= IDLE_SYNC;
            vs_q         <= IDLE_SYNC;
            de_q         <= 1'b0;
        end else begin
            vs_d_q <= vid.src_vsync;
            rgb_q  <= mute_d ? '0 : sel_rgb;
            hs_q   <= vid.src_hsync[mux_sel];
            vs_q   <= vid.src_vsync[mux_sel];
            de_q   <= vid.src_de[mux_sel];
            case (state_q)
                RUN: begin
                    if (sel_ok && (vid.sel_in != active_sel_q)) begin
                        pend_sel_q <= vid.sel_in;
                        tcnt_q     <= '0;
                        state_q    <= PENDING;
                        busy_q     <= 1'b1;
                    end
                end
                PENDING: begin
                    if (switch_now) begin
                        active_sel_q <= pend_sel_q;
                        if (BLACK_FRAMES > 0) begin
                            bcnt_q  <= BLOAD;
                            state_q <= BLANK;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        tcnt_q <= sat_inc(tcnt_q);
                        // Requesting the current source again withdraws the switch.
                        if (sel_ok && (vid.sel_in == active_sel_q)) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end else if (sel_ok) begin
                            pend_sel_q <= vid.sel_in;
                        end
                    end
                end
                BLANK: begin
                    if (lead_act) begin
                        bcnt_q <= bcnt_q - 1'b1;
                        if (blank_end) begin
                            state_q <= RUN;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign vid.rgb_out     = rgb_q;
    assign vid.hsync_out   = hs_q;
    assign vid.vsync_out   = vs_q;
    assign vid.de_out      = de_q;
    assign vid.active_sel  = active_sel_q;
    assign vid.switch_busy = busy_q;
endmodule

// File: tb/tb_video_src_switch.sv
// Bench for video_src_switch: two configurations (active-high/black-frame and
// active-low/no-mute) driven by shared synthetic sources and checked against a frame-level model.
module tb_video_src_switch;
    localparam int DW = 8;

    logic pix_clk = 1'b0;
    logic rst;
    always #5 pix_clk = ~pix_clk;

    video_src_switch_if #(.NUM_SRC(4), .DATA_W(DW)) va();
    video_src_switch_if #(.NUM_SRC(3), .DATA_W(DW)) vb();

    video_src_switch #(
        .NUM_SRC(4), .DATA_W(DW), .SYNC_POL(1'b1), .DEFAULT_SRC(0),
        .BLACK_FRAMES(1), .TIMEOUT_CYC(100)
    ) u_a (
        .pix_clk (pix_clk),
        .rst     (rst),
        .vid     (va.slave)
    );

    video_src_switch #(
        .NUM_SRC(3), .DATA_W(DW), .SYNC_POL(1'b0), .DEFAULT_SRC(1),
        .BLACK_FRAMES(0), .TIMEOUT_CYC(50)
    ) u_b (
        .pix_clk (pix_clk),
        .rst     (rst),
        .vid     (vb.slave)
    );

    // Source streams in active-level terms; instance B sees inverted sync pins.
    int          per [4] = '{37, 43, 53, 61};
    int          ph  [4] = '{0, 11, 23, 5};
    bit          hold0;
    logic [3:0]  s_hs, s_vs, s_de;
    logic [23:0] s_rgb [4];
    int          sel_a, sel_b;

    // Configuration of the two instances, as seen by the model.
    int c_n   [2] = '{4, 3};
    int c_bf  [2] = '{1, 0};
    int c_to  [2] = '{100, 50};
    int c_def [2] = '{0, 1};
    bit c_pol [2] = '{1'b1, 1'b0};

    // Model state: which source is shown, an outstanding request, frames left to mute.
    int         m_active [2];
    int         m_target [2];
    int         m_wait   [2];
    int         m_mute   [2];
    bit         m_pend   [2];
    logic [3:0] m_prev   [2];

    logic [23:0] e_rgb  [2];
    logic        e_hs   [2];
    logic        e_vs   [2];
    logic        e_de   [2];
    int          e_sel  [2];
    logic        e_busy [2];

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen_srcs();
        for (int k = 0; k < 4; k++) begin
            ph[k]    = (ph[k] + 1) % per[k];
            s_vs[k]  = (ph[k] < 3) && !(k == 0 && hold0);
            s_hs[k]  = (ph[k] % 10) < 2;
            s_de[k]  = (ph[k] >= 5) && ((ph[k] % 10) >= 3);
            s_rgb[k] = 24'($urandom);
        end
    endtask

    task automatic drive();
        va.src_rgb   = {s_rgb[3], s_rgb[2], s_rgb[1], s_rgb[0]};
        va.src_hsync = s_hs;
        va.src_vsync = s_vs;
        va.src_de    = s_de;
        va.sel_in    = 2'(sel_a);
        vb.src_rgb   = {s_rgb[2], s_rgb[1], s_rgb[0]};
        vb.src_hsync = ~s_hs[2:0];
        vb.src_vsync = ~s_vs[2:0];
        vb.src_de    = s_de[2:0];
        vb.sel_in    = 2'(sel_b);
    endtask

    task automatic model_step(input int i, input bit r, input int sel);
        bit ld, fire, muted, valid;
        int src;
        if (r) begin
            m_active[i] = c_def[i];
            m_target[i] = c_def[i];
            m_pend[i]   = 1'b0;
            m_wait[i]   = 0;
            m_mute[i]   = 0;
            m_prev[i]   = '0;
            e_rgb[i]    = '0;
            e_hs[i]     = ~c_pol[i];
            e_vs[i]     = ~c_pol[i];
            e_de[i]     = 1'b0;
            e_sel[i]    = c_def[i];
            e_busy[i]   = 1'b0;
            return;
        end
        valid = sel < c_n[i];
        ld    = s_vs[m_active[i]] && !m_prev[i][m_active[i]];
        fire  = m_pend[i] && (ld || m_wait[i] == c_to[i] - 1);
        src   = fire ? m_target[i] : m_active[i];
        muted = (fire && c_bf[i] > 0) || (m_mute[i] > 0 && !(ld && m_mute[i] == 1));
        e_rgb[i] = muted ? 24'h0 : s_rgb[src];
        e_hs[i]  = c_pol[i] ? s_hs[src] : ~s_hs[src];
        e_vs[i]  = c_pol[i] ? s_vs[src] : ~s_vs[src];
        e_de[i]  = s_de[src];
        if (m_mute[i] > 0) begin
            if (ld) m_mute[i]--;
        end else if (m_pend[i]) begin
            if (fire) begin
                m_active[i] = m_target[i];
                m_pend[i]   = 1'b0;
                m_mute[i]   = c_bf[i];
            end else begin
                m_wait[i]++;
                if (valid && sel == m_active[i]) m_pend[i] = 1'b0;
                else if (valid) m_target[i] = sel;
            end
        end else if (valid && sel != m_active[i]) begin
            m_pend[i]   = 1'b1;
            m_target[i] = sel;
            m_wait[i]   = 0;
        end
        m_prev[i] = s_vs;
        e_sel[i]  = m_active[i];
        e_busy[i] = m_pend[i] || (m_mute[i] > 0);
    endtask

    task automatic step();
        drive();
        model_step(0, rst, sel_a);
        model_step(1, rst, sel_b);
        @(posedge pix_clk);
        #1;
        chk("a_rgb",  va.rgb_out,     e_rgb[0]);
        chk("a_hs",   va.hsync_out,   e_hs[0]);
        chk("a_vs",   va.vsync_out,   e_vs[0]);
        chk("a_de",   va.de_out,      e_de[0]);
        chk("a_sel",  va.active_sel,  e_sel[0]);
        chk("a_busy", va.switch_busy, e_busy[0]);
        chk("b_rgb",  vb.rgb_out,     e_rgb[1]);
        chk("b_hs",   vb.hsync_out,   e_hs[1]);
        chk("b_vs",   vb.vsync_out,   e_vs[1]);
        chk("b_de",   vb.de_out,      e_de[1]);
        chk("b_sel",  vb.active_sel,  e_sel[1]);
        chk("b_busy", vb.switch_busy, e_busy[1]);
        gen_srcs();
    endtask

    initial begin
        int cnt;
        n_vec = 0;
        n_err = 0;
        hold0 = 1'b0;
        sel_a = 0;
        sel_b = 1;
        rst   = 1'b1;
        gen_srcs();
        repeat (3) step();
        chk("rst_a_rgb", va.rgb_out, 24'h0);
        chk("rst_a_hs",  va.hsync_out, 1'b0);
        chk("rst_b_vs",  vb.vsync_out, 1'b1);
        chk("rst_b_sel", vb.active_sel, 1);
        rst = 1'b0;
        repeat (20) step();

        // Mid-frame request for source 3, followed through to the end of the black frame.
        cnt = 0;
        while (ph[0] != 15 && cnt < 100) begin step(); cnt++; end
        sel_a = 3;
        step();
        chk("sw_busy", va.switch_busy, 1'b1);
        chk("sw_hold", va.active_sel, 0);
        cnt = 0;
        while (va.switch_busy && cnt < 400) begin step(); cnt++; end
        chk("sw_done", va.switch_busy, 1'b0);
        chk("sw_sel",  va.active_sel, 3);

        // Back to 0, then a request for 2 withdrawn before any vsync edge.
        sel_a = 0;
        cnt = 0;
        while ((va.switch_busy || va.active_sel != 0) && cnt < 400) begin step(); cnt++; end
        cnt = 0;
        while (ph[0] != 10 && cnt < 100) begin step(); cnt++; end
        sel_a = 2;
        repeat (3) step();
        sel_a = 0;
        repeat (5) step();
        chk("cancel_sel",  va.active_sel, 0);
        chk("cancel_busy", va.switch_busy, 1'b0);

        // Source 0 vsync frozen: the switch must be forced by the timeout.
        hold0 = 1'b1;
        repeat (2) step();
        sel_a = 1;
        step();
        chk("to_busy", va.switch_busy, 1'b1);
        cnt = 0;
        while (va.active_sel != 1 && cnt < 300) begin step(); cnt++; end
        chk("to_cycles", cnt, 100);
        cnt = 0;
        while (va.switch_busy && cnt < 400) begin step(); cnt++; end
        chk("to_done", va.switch_busy, 1'b0);
        hold0 = 1'b0;

        // Out-of-range request on the 3-source instance, then a switch with no muting.
        sel_b = 3;
        repeat (60) step();
        chk("inv_busy", vb.switch_busy, 1'b0);
        chk("inv_sel",  vb.active_sel, 1);
        sel_b = 2;
        step();
        cnt = 0;
        while (vb.switch_busy && cnt < 200) begin step(); cnt++; end
        chk("nomute_sel", vb.active_sel, 2);

        // Reset while blanking.
        sel_a = 2;
        cnt = 0;
        while (!(va.switch_busy && va.active_sel == 2) && cnt < 400) begin step(); cnt++; end
        chk("blank_reached", va.active_sel, 2);
        rst = 1'b1;
        step();
        chk("rstb_sel",  va.active_sel, 0);
        chk("rstb_busy", va.switch_busy, 1'b0);
        chk("rstb_rgb",  va.rgb_out, 24'h0);
        chk("rstb_vs",   va.vsync_out, 1'b0);
        rst = 1'b0;

        // Random requests and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) sel_a = $urandom_range(0, 3);
            if ($urandom_range(0, 39) == 0) sel_b = $urandom_range(0, 3);
            if ($urandom_range(0, 199) == 0) hold0 = ~hold0;
            rst = ($urandom_range(0, 999) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
